interval_timer_arbiter: RTL and testbench
=========================================

// Module: interval_timer_arbiter
// PURPOSE
// - Shares one internal interval counter among `channels` requesters, each asking for a timed interval.
// - Round-robin arbitration picks the next channel; the block loads that channel's duration and runs the count.
// - It signals completion to the granted channel.
// - Sits between sequencing logic, which needs timed waits, and a single counter resource.
// PARAMETERS
// - channels  default 4  number of requesters, 2..16
// - bitwidth  default 8  width of a duration and of the count value
// - idxwidth  default 2  width of the channel index; must be >= clog2(channels)
// PORTS
// - clock           input   1                   rising-edge clock
// - reset           input   1                   asynchronous, active-high
// - request         input   channels            level request per channel; hold until done or to cancel
// - duration        input   channels*bitwidth   packed; channel i duration at [i*bitwidth +: bitwidth], in clock cycles
// - grant           output  channels            one-hot, registered; channel owning the counter
// - active_channel  output  idxwidth            index of the granted channel; valid while busy
// - busy            output  1                   high in LOAD, RUN and DONE
// - value           output  bitwidth            running count, 0..D-1
// - done            output  channels            one-cycle pulse to the granted channel at interval end
// - error           output  1                   one-cycle pulse with done when the latched duration was 0
// BEHAVIOUR
// - Reset: asynchronous. All outputs 0, state=IDLE, rr pointer=0, active_reload=0.
// - States: IDLE -> LOAD -> RUN -> DONE -> IDLE. LOAD -> DONE when the duration is 0.
// - IDLE:
//   - If any request bit is set, pick the first set bit searching upward from the pointer, wrapping at channels-1.
//   - Next edge: grant=onehot(pick), active_channel=pick, state=LOAD.
//   - No request: stay in IDLE, all outputs 0.
// - LOAD:
//   - Edge: active_reload <= duration[ch], value <= 0.
//   - Nonzero duration: state=RUN. Zero duration: state=DONE with error armed.
//   - Durations are sampled only here; later changes are ignored until the next grant.
// - RUN:
//   - Each edge value <= value+1.
//   - At the edge where value==active_reload-1: state=DONE; value holds.
//   - RUN lasts exactly D cycles.
// - DONE:
//   - Exactly one cycle. done[ch]=1, error=1 if D was 0, grant still held.
//   - Next edge: grant=0, busy=0, value=0, pointer=(ch+1) mod channels, state=IDLE.
// - Cancel: request[ch] low during LOAD or RUN.
//   - Next edge: state=IDLE, grant=0, value=0, no done pulse, pointer advances as in DONE.
// - Request held through DONE: the channel is re-arbitrated in the following IDLE cycle.
//   - Round-robin gives other waiting channels priority first.
// - Latency: request seen in IDLE at cycle 0 -> grant at 1, RUN at 2..D+1, done at D+2.
//   - Back-to-back grants are separated by one IDLE cycle.
//   - Worst-case wait: (channels-1)*(D_max+3) cycles.
// - Simultaneous new requests while busy: ignored until IDLE. No queueing beyond the level request.
// - Reset mid-RUN: immediate return to reset values. No done pulse.
// - Arithmetic: value is unsigned bitwidth. D_max = 2^bitwidth-1, so it never wraps.
// - Comparison value==active_reload-1 is done at bitwidth width; guarded by the D!=0 path.
// STRUCTURE
// - Include header interval_timer_arbiter_defs.vh: state localparams IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3.
//   - Guarded by `ifndef; `include only.
// - Sub-module rr_arbiter #(channels, idxwidth).
//   - Inputs: request, pointer. Outputs: found, index.
//   - Purely combinational masked priority search with wrap.
// - Top holds the FSM, pointer, active_reload, value, and the grant/done/error registers.
// TESTING
// - Single channel: ch1 requests, D=5 -> grant[1] at cycle 1, value 0..4, done[1] pulse at cycle 7, busy low at 8.
// - Round-robin: ch0 and ch2 request continuously, D=2 each.
//   - Grants alternate 0,2,0,2, separated by one IDLE cycle. Pointer ends at 1 after a ch0 grant.
// - Zero duration: ch3 D=0 -> LOAD->DONE; done[3] and error pulse together, value stays 0.
// - Cancel: ch0 D=10, request dropped at value=4 -> IDLE next edge, no done; waiting ch1 granted the next cycle.
// - Duration change: ch2 D=3 latched, then duration changed to 9 mid-RUN -> RUN still lasts 3 cycles.
// - Async reset during RUN at value=6 -> all outputs 0 at once; after release, pointer=0 and ch0 wins over ch1.

Source files
------------

// File: rtl/interval_timer_arbiter_pkg.sv
// Shared types and helpers for the interval timer arbiter.
package interval_timer_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } state_t;

    function automatic int unsigned wrap_next(int unsigned idx, int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/interval_timer_arbiter_rr_arbiter.sv
// Combinational round-robin search: first set request at or above pointer, wrapping.
module rr_arbiter
    import interval_timer_arbiter_pkg::*;
#(
    parameter int unsigned channels = 4,
    parameter int unsigned idxwidth = 2
) (
    input  logic [channels-1:0] request,
    input  logic [idxwidth-1:0] pointer,
    output logic                found,
    output logic [idxwidth-1:0] index
);

    logic [idxwidth-1:0] cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int unsigned k = 0; k < channels; k++) begin
            cand = idxwidth'((32'(pointer) + k) % channels);
            if (!found && request[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/interval_timer_arbiter.sv
// Shares one interval counter among round-robin arbitrated requesters and pulses
// done to the owner when its latched duration has elapsed.
module interval_timer_arbiter
    import interval_timer_arbiter_pkg::*;
#(
    parameter int unsigned channels = 4,
    parameter int unsigned bitwidth = 8,
    parameter int unsigned idxwidth = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [channels-1:0]          request,
    input  logic [channels*bitwidth-1:0] duration,
    output logic [channels-1:0]          grant,
    output logic [idxwidth-1:0]          active_channel,
    output logic                         busy,
    output logic [bitwidth-1:0]          value,
    output logic [channels-1:0]          done,
    output logic                         error
);

    state_t                state_q, state_d;
    logic [idxwidth-1:0]   pointer_q, pointer_d;
    logic [idxwidth-1:0]   active_q, active_d;
    logic [bitwidth-1:0]   reload_q, reload_d;
    logic [bitwidth-1:0]   value_q, value_d;
    logic [channels-1:0]   grant_q, grant_d;
    logic [channels-1:0]   done_q, done_d;
    logic                  error_q, error_d;

    logic                  found;
    logic [idxwidth-1:0]   pick;
    logic [bitwidth-1:0]   chan_duration;
    logic                  release_owner;

    rr_arbiter #(
        .channels (channels),
        .idxwidth (idxwidth)
    ) u_rr (
        .request (request),
        .pointer (pointer_q),
        .found   (found),
        .index   (pick)
    );

    assign chan_duration = duration[active_q*bitwidth +: bitwidth];

    always_comb begin
        state_d       = state_q;
        pointer_d     = pointer_q;
        active_d      = active_q;
        reload_d      = reload_q;
        value_d       = value_q;
        grant_d       = grant_q;
        done_d        = '0;
        error_d       = 1'b0;
        release_owner = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    active_d      = pick;
                    state_d       = StLoad;
                end
            end
            StLoad: begin
                if (!request[active_q]) begin
                    release_owner = 1'b1;
                end else begin
                    reload_d = chan_duration;
                    value_d  = '0;
                    if (chan_duration == '0) begin
                        state_d = StDone;
                        done_d  = grant_q;
                        error_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // Dropping the request cancels, even on the final count.
                if (!request[active_q]) begin
                    release_owner = 1'b1;
                end else if (value_q == reload_q - bitwidth'(1)) begin
                    state_d = StDone;
                    done_d  = grant_q;
                end else begin
                    value_d = value_q + bitwidth'(1);
                end
            end
            StDone: begin
                release_owner = 1'b1;
            end
        endcase

        if (release_owner) begin
            state_d   = StIdle;
            grant_d   = '0;
            active_d  = '0;
            value_d   = '0;
            pointer_d = idxwidth'(wrap_next(32'(active_q), channels));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pointer_q <= '0;
            active_q  <= '0;
            reload_q  <= '0;
            value_q   <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pointer_q <= pointer_d;
            active_q  <= active_d;
            reload_q  <= reload_d;
            value_q   <= value_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign grant          = grant_q;
    assign active_channel = active_q;
    assign busy           = (state_q != StIdle);
    assign value          = value_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Randomized bench for interval_timer_arbiter against a timeline-based reference model.
module tb_interval_timer_arbiter;

    localparam int Ch = 4;
    localparam int Bw = 8;
    localparam int Iw = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [Ch-1:0]     request = '0;
    logic [Ch*Bw-1:0]  duration = '0;
    logic [Ch-1:0]     grant;
    logic [Iw-1:0]     active_channel;
    logic              busy;
    logic [Bw-1:0]     value;
    logic [Ch-1:0]     done;
    logic              error;

    interval_timer_arbiter #(
        .channels (Ch),
        .bitwidth (Bw),
        .idxwidth (Iw)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .request        (request),
        .duration       (duration),
        .grant          (grant),
        .active_channel (active_channel),
        .busy           (busy),
        .value          (value),
        .done           (done),
        .error          (error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: owner (-1 when free), t = cycles since grant, d = latched duration.
    // t==0 is the load cycle, 1..d are counting cycles, d+1 is the completion cycle.
    int m_owner = -1;
    int m_t     = 0;
    int m_d     = 0;
    int m_ptr   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dur_of(input int i);
        return int'(duration[i*Bw +: Bw]);
    endfunction

    function automatic logic [Bw-1:0] rand_dur();
        if ($urandom_range(0, 19) == 0) return Bw'($urandom_range(13, 40));
        return Bw'($urandom_range(0, 12));
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_t     = 0;
        m_d     = 0;
        m_ptr   = 0;
    endtask

    task automatic model_release();
        m_ptr   = (m_owner + 1) % Ch;
        m_owner = -1;
        m_t     = 0;
    endtask

    task automatic model_edge();
        int pick;
        if (m_owner < 0) begin
            pick = -1;
            for (int k = 0; k < Ch; k++) begin
                if (pick < 0 && request[(m_ptr + k) % Ch]) pick = (m_ptr + k) % Ch;
            end
            if (pick >= 0) begin
                m_owner = pick;
                m_t     = 0;
            end
        end else if (m_t == 0) begin
            if (!request[m_owner]) model_release();
            else begin
                m_d = dur_of(m_owner);
                m_t = 1;
            end
        end else if (m_t == m_d + 1) begin
            model_release();
        end else begin
            if (!request[m_owner]) model_release();
            else m_t++;
        end
    endtask

    task automatic compare_all();
        int e_busy, e_grant, e_ch, e_val, e_done, e_err;
        e_busy  = (m_owner >= 0) ? 1 : 0;
        e_grant = e_busy ? (1 << m_owner) : 0;
        e_ch    = e_busy ? m_owner : 0;
        if (!e_busy || m_t == 0) e_val = 0;
        else if (m_t <= m_d) e_val = m_t - 1;
        else e_val = (m_d == 0) ? 0 : m_d - 1;
        e_done  = (e_busy && m_t >= 1 && m_t == m_d + 1) ? (1 << m_owner) : 0;
        e_err   = (e_done != 0 && m_d == 0) ? 1 : 0;
        check_eq("busy", 32'(busy), 32'(e_busy));
        check_eq("grant", 32'(grant), 32'(e_grant));
        check_eq("active_channel", 32'(active_channel), 32'(e_ch));
        check_eq("value", 32'(value), 32'(e_val));
        check_eq("done", 32'(done), 32'(e_done));
        check_eq("error", 32'(error), 32'(e_err));
    endtask

    task automatic step();
        @(posedge clock);
        if (!reset) model_edge();
        @(negedge clock);
        compare_all();
    endtask

    task automatic drive_random();
        for (int i = 0; i < Ch; i++) begin
            if (!request[i]) begin
                if ($urandom_range(0, 3) == 0) begin
                    request[i] = 1'b1;
                    duration[i*Bw +: Bw] = rand_dur();
                end
            end else if (i == m_owner && m_t >= 1 && m_t == m_d + 1) begin
                if ($urandom_range(0, 1) == 0) request[i] = 1'b0;
            end else if (i == m_owner && $urandom_range(0, 29) == 0) begin
                request[i] = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) duration[i*Bw +: Bw] = rand_dur();
        end
    endtask

    initial begin
        int got_done;
        int reached;

        // Reset values
        model_reset();
        #2;
        compare_all();
        @(negedge clock);
        reset = 1'b0;
        step();

        // Single channel, D=5: done expected at cycle 7, idle at 8
        request = 4'b0010;
        duration[1*Bw +: Bw] = 8'd5;
        got_done = -1;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (done == 4'b0010 && got_done < 0) got_done = k;
            if (k == 7) request = '0;
            if (k == 8) check_eq("single_busy_low_at_8", 32'(busy), 32'd0);
        end
        check_eq("single_done_cycle", 32'(got_done), 32'd7);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive_random();
            step();
        end

        // Drain, then reset in the middle of a count
        request = '0;
        for (int n = 0; n < 100 && m_owner >= 0; n++) step();
        check_eq("drained", 32'(busy), 32'd0);
        request = 4'b0010;
        duration[1*Bw +: Bw] = 8'd10;
        reached = 0;
        for (int n = 0; n < 40 && reached == 0; n++) begin
            step();
            if (m_owner == 1 && m_t == 7) reached = 1;
        end
        check_eq("reached_value_6", 32'(reached), 32'd1);
        check_eq("value_before_reset", 32'(value), 32'd6);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        request = 4'b0011;
        duration[0*Bw +: Bw] = 8'd3;
        duration[1*Bw +: Bw] = 8'd3;
        @(negedge clock);
        reset = 1'b0;
        step();
        check_eq("post_reset_ch0_wins", 32'(grant), 32'h1);
        for (int n = 0; n < 12; n++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
